// File: rtl/seq_pkg.sv
// Shared helpers for the parametrised serial sequence detector:
// width derivation and the names of the two detection modes.
package seq_pkg;

    // Detection mode names for the OVERLAP parameter.
    localparam logic MODE_OVERLAP = 1'b1;
    localparam logic MODE_RESTART = 1'b0;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // The state holds a matched-prefix length 0..n, so it needs n+1 codes.
    function automatic int state_width(input int n);
        return clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter: counts inc pulses, sticks at all-ones,
// clr wins over a simultaneous inc, RESET wins over everything.
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, then saturating increment, else hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector. S is the length of the longest
// pattern prefix that ends at the most recent accepted bit; F flags S==N.
// en is a plain sample qualifier: every enabled edge consumes x, there is
// no ready/backpressure path, and en=0 freezes state, history and count.
module seq_detector_param
    import seq_pkg::*;
#(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1101,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8,
    localparam int            SW      = state_width(N)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             x,
    input  logic             en,
    input  logic             cnt_clr,
    output logic             F,
    output logic [SW-1:0]    S,
    output logic [CNT_W-1:0] match_cnt
);

    // Parameter legality is checked while elaborating.
    generate
        if (N < 2 || N > 16) begin : g_bad_n
            $error("seq_detector_param: N=%0d outside legal range 2..16", N);
        end
        if (OVERLAP != int'(MODE_OVERLAP) && OVERLAP != int'(MODE_RESTART)) begin : g_bad_mode
            $error("seq_detector_param: OVERLAP=%0d must be 0 or 1", OVERLAP);
        end
    endgenerate

    // Named state codes: empty prefix, one bit matched, full match.
    localparam logic [SW-1:0] S_IDLE = '0;
    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [SW-1:0] S_FULL = SW'(N);

    localparam bit RESTART_MODE = (OVERLAP == int'(MODE_RESTART));

    logic [SW-1:0] s_q;
    logic [SW-1:0] s_d;
    logic [N-2:0]  hist_q;
    logic [N-2:0]  hist_d;
    logic [N-1:0]  cand;
    logic          match_inc;

    // Longest k <= min(s+1, N) whose last k candidate bits equal the first
    // k pattern bits. cand[0] is the newest bit, so the candidate suffix of
    // length k sits in cand[k-1:0] and the pattern prefix is PATTERN >> (N-k).
    function automatic logic [SW-1:0] kmp_next(input logic [SW-1:0] s,
                                               input logic [N-1:0]  c);
        int            limit;
        logic          found;
        logic [SW-1:0] result;
        logic [31:0]   mask32;
        logic [N-1:0]  mask;
        logic [N-1:0]  prefix;
        limit  = int'(s) + 1;
        if (limit > N) begin
            limit = N;
        end
        found  = 1'b0;
        result = S_IDLE;
        for (int k = N; k >= 1; k--) begin
            mask32 = (32'd1 << k) - 32'd1;
            mask   = mask32[N-1:0];
            prefix = PATTERN >> (N - k);
            if (!found && (k <= limit) && ((c & mask) == prefix)) begin
                found  = 1'b1;
                result = SW'(k);
            end
        end
        return result;
    endfunction

    // Next state and history; in restart mode a full match forgets history.
    always_comb begin
        cand   = {hist_q, x};
        s_d    = s_q;
        hist_d = hist_q;
        if (en) begin
            hist_d = cand[N-2:0];
            if (RESTART_MODE && (s_q == S_FULL)) begin
                s_d = (x == PATTERN[N-1]) ? S_ONE : S_IDLE;
            end else begin
                s_d = kmp_next(s_q, cand);
            end
        end
    end

    // A match is counted on the enabled edge that lands in the full state.
    always_comb begin
        match_inc = en && (s_d == S_FULL);
    end

    // State and history registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s_q    <= S_IDLE;
            hist_q <= '0;
        end else begin
            s_q    <= s_d;
            hist_q <= hist_d;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (match_inc),
        .clr   (cnt_clr),
        .count (match_cnt)
    );

    assign S = s_q;
    assign F = (s_q == S_FULL);

    // The matched-prefix length can never run past the pattern length.
    a_state_bound: assert property (@(posedge CLK) disable iff (RESET) s_q <= S_FULL);

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the fixed serial-input sequence detector FSM.
- Detects a programmable N-bit pattern on the 1-bit serial input `x`, sampled one bit per enabled clock.
- Selectable overlapping or non-overlapping detection.
- Exposes the Moore detect flag `F`, the current state `S` (matched-prefix length) and a saturating match counter.
- Sits beside the existing detector as its drop-in generalisation.

Parameters:
- N, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101: pattern to detect; bit N-1 is received first.
- OVERLAP, 1: 1 = overlapping detection, 0 = restart after each match.
- CNT_W, 8: width of the match counter.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- x  input  1  serial data bit, sampled on CLK rising edge when en=1.
- en  input  1  sample enable; 0 = hold all state.
- cnt_clr  input  1  synchronous clear of match_cnt.
- F  output  1  detect flag, high while S==N (Moore).
- S  output  SW  current state = matched-prefix length 0..N; SW = clog2(N+1).
- match_cnt  output  CNT_W  number of completed matches, saturating.

Behaviour:
- Clocking and reset: one clock. RESET is synchronous, active-high and overrides en and cnt_clr.
- Reset values: S=0, F=0, match_cnt=0, history register (N-1 bits) = 0.
- State meaning: S=k means the last k accepted bits equal PATTERN[N-1 -: k].
- F encoding: F = (S==N), decoded combinationally from the state register. It is high for exactly one cycle per match unless en holds the state.
- Latency: the bit that completes the pattern is sampled on edge t; S=N and F=1 from edge t until the next enabled edge.
- Next state (en=1): candidate string is the history bits followed by x. The next S is the largest k ≤ min(S+1, N) such that the last k candidate bits equal the first k pattern bits, else 0.
  - This is a KMP-equivalent transition, computed combinationally with a descending k loop.
  - The state is never allowed to exceed N.
- From S=N with OVERLAP=1: same rule applies with S+1 capped to N, giving the longest proper border extension.
- From S=N with OVERLAP=0: the history is treated as empty, so next S = (x==PATTERN[N-1]) ? 1 : 0.
- en=0: S, history and match_cnt hold (cnt_clr is still honoured). F stays at its current value.
- History register: shifts in x on every enabled edge, independent of state. It holds the last N-1 accepted bits.
- Counter update: match_cnt increments on the edge where next S==N.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr takes priority over a simultaneous increment; result 0.
- Mid-operation reset: RESET asserted on any edge yields S=0, F=0, match_cnt=0 on that edge. Detection restarts cleanly with the first bit sampled after RESET deasserts.
- Illegal parameters: N outside 2..16 must trigger an elaboration-time error.

Decomposition:
- Shared package seq_pkg holds:
  - clog2 function;
  - SW derivation helper;
  - localparams for OVERLAP mode names (MODE_OVERLAP=1, MODE_RESTART=0).
- One natural sub-module, seq_match_counter. It is a CNT_W saturating counter with inc, clr, CLK and RESET ports.
- Next-state logic stays in the top module as a combinational function.

Test Plan:
- Reset hold: RESET=1 for 5 cycles with x toggling -> S=0, F=0, match_cnt=0 throughout. Deassert RESET -> first enabled bit x=1 gives S=1.
- Overlap, N=4, PATTERN=1101, OVERLAP=1: x = 1,1,0,1,1,0,1 -> S = 1,2,3,4,2,3,4. F high after bits 4 and 7; match_cnt=2.
- Non-overlap, same stream with OVERLAP=0 -> S = 1,2,3,4,1,0,1. F high once; match_cnt=1.
- Self-loop fallback: x = 1,1,1,0,1 -> S = 1,2,2,3,4; F=1 after bit 5.
- Enable/clear: reach S=3, drop en for 3 cycles with x=0 -> S stays 3. Raise en with x=1 -> S=4, F=1. Assert cnt_clr on the same edge as a match -> match_cnt=0.
- Saturation and mid-reset: CNT_W=2 with 5 overlapping matches -> match_cnt caps at 3. Then RESET while S=3 -> S=0, F=0, match_cnt=0 on the next edge.
